// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared lane/select constants and types for the 1:8 demux
//
// Purpose : common sizing for demux_1_x_8_reg and decoder_3_x_8.
// Contents: LANES, SEL_W, sel_t, onehot_t, LAST_LANE (pointer value that wraps).
package demux_pkg;
  localparam int LANES = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [LANES-1:0] onehot_t;

  localparam logic [SEL_W-1:0] LAST_LANE = SEL_W'(LANES - 1);
endpackage

// File: rtl/decoder_3_x_8.sv
// rtl/decoder_3_x_8.sv - gated 3-to-8 one-hot decoder for lane write enables
//
// Purpose : turns a lane index into a one-hot write enable, all zero when disabled.
// Ports   :
//   sel_i     in  3  lane index
//   en_i      in  1  decode enable (write request)
//   onehot_o  out 8  1<<sel_i when en_i, else 0
module decoder_3_x_8
  import demux_pkg::*;
(
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [LANES-1:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[sel_i] = 1'b1;
    end
  end

endmodule

// File: rtl/demux_1_x_8_reg.sv
// rtl/demux_1_x_8_reg.sv - registered 1:8 demultiplexer / frame deserializer
//
// Purpose : routes d_i into one of eight held lanes, chosen by s_i (manual) or
//           by an internal wrapping pointer (auto) that rebuilds 8-word frames.
// Option  : DEMUX_FRAME_CNT_EN adds frame_cnt_o, a wrapping count of frames.
// Ports   :
//   clk_i         in   1  clock, rising edge
//   rst_i         in   1  synchronous active-high reset
//   d_i           in   N  data word
//   s_i           in   3  lane select when auto_i=0
//   load_i        in   1  write strobe
//   auto_i        in   1  1: lane=ptr, 0: lane=s_i
//   clear_i       in   1  synchronous clear, below rst_i, above load_i
//   z0_o..z7_o    out  N  held lanes
//   wr_onehot_o   out  8  one-hot of lane written at the previous edge
//   ptr_o         out  3  auto pointer
//   frame_done_o  out  1  pulse after the auto write to lane 7
//   frame_cnt_o   out  8  frame counter (DEMUX_FRAME_CNT_EN only)
module demux_1_x_8_reg
  import demux_pkg::*;
#(
  parameter int N = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     d_i,
  input  logic [SEL_W-1:0] s_i,
  input  logic             load_i,
  input  logic             auto_i,
  input  logic             clear_i,
  output logic [N-1:0]     z0_o,
  output logic [N-1:0]     z1_o,
  output logic [N-1:0]     z2_o,
  output logic [N-1:0]     z3_o,
  output logic [N-1:0]     z4_o,
  output logic [N-1:0]     z5_o,
  output logic [N-1:0]     z6_o,
  output logic [N-1:0]     z7_o,
  output logic [LANES-1:0] wr_onehot_o,
  output logic [SEL_W-1:0] ptr_o,
  output logic             frame_done_o
`ifdef DEMUX_FRAME_CNT_EN
  ,
  output logic [7:0]       frame_cnt_o
`endif
);

  logic [N-1:0]     z_q [LANES];
  logic [SEL_W-1:0] lane;
  logic             wr_req;
  logic             auto_wr;
  logic             wrap;
  logic [LANES-1:0] we;

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [LANES-1:0] wr_onehot_q, wr_onehot_d;
  logic             frame_done_q, frame_done_d;

  // clear wins over load, so a clear cycle never produces a write enable.
  assign wr_req  = load_i && !clear_i;
  assign lane    = auto_i ? ptr_q : s_i;
  assign auto_wr = wr_req && auto_i;
  // The control state (IDLE when ptr==0, FILL otherwise) lives entirely in
  // ptr_q; the FILL->IDLE transition is the auto write at the last lane.
  assign wrap    = auto_wr && (ptr_q == LAST_LANE);

  decoder_3_x_8 u_dec (
    .sel_i    (lane),
    .en_i     (wr_req),
    .onehot_o (we)
  );

  generate
    for (genvar i = 0; i < LANES; i++) begin : g_lane
      always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
          z_q[i] <= '0;
        end else if (we[i]) begin
          z_q[i] <= d_i;
        end
      end
    end
  endgenerate

  assign ptr_d        = auto_wr ? ptr_q + 1'b1 : ptr_q;
  assign wr_onehot_d  = we;
  assign frame_done_d = wrap;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      ptr_q        <= '0;
      wr_onehot_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      wr_onehot_q  <= wr_onehot_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef DEMUX_FRAME_CNT_EN
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // Counts in the same edge that raises frame_done; wraps naturally at 8 bits.
  assign frame_cnt_d = wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

  assign z0_o         = z_q[0];
  assign z1_o         = z_q[1];
  assign z2_o         = z_q[2];
  assign z3_o         = z_q[3];
  assign z4_o         = z_q[4];
  assign z5_o         = z_q[5];
  assign z6_o         = z_q[6];
  assign z7_o         = z_q[7];
  assign wr_onehot_o  = wr_onehot_q;
  assign ptr_o        = ptr_q;
  assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_demux_1_x_8_reg.sv
// tb/tb_demux_1_x_8_reg.sv - scoreboard bench for demux_1_x_8_reg
module tb_demux_1_x_8_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] d = '0;
  logic [2:0] s = '0;
  logic       load = 1'b0;
  logic       auto_m = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] z [8];
  logic [7:0] wr_onehot;
  logic [2:0] ptr;
  logic       frame_done;
  logic [7:0] frame_cnt;

  always #5 clk = ~clk;

  demux_1_x_8_reg #(.N(4)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .d_i          (d),
    .s_i          (s),
    .load_i       (load),
    .auto_i       (auto_m),
    .clear_i      (clear),
    .z0_o         (z[0]),
    .z1_o         (z[1]),
    .z2_o         (z[2]),
    .z3_o         (z[3]),
    .z4_o         (z[4]),
    .z5_o         (z[5]),
    .z6_o         (z[6]),
    .z7_o         (z[7]),
    .wr_onehot_o  (wr_onehot),
    .ptr_o        (ptr),
    .frame_done_o (frame_done)
`ifdef DEMUX_FRAME_CNT_EN
    ,
    .frame_cnt_o  (frame_cnt)
`endif
  );

`ifndef DEMUX_FRAME_CNT_EN
  assign frame_cnt = 8'd0;
`endif

  typedef struct {
    logic [7:0][3:0] z;
    logic [2:0]      ptr;
    logic [7:0]      oh;
    logic            fd;
    logic [7:0]      cnt;
  } exp_t;

  exp_t            q[$];
  logic [7:0][3:0] exp_z = '0;
  logic [7:0]      exp_cnt = '0;
  int              n_checks = 0;
  int              n_pass = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endfunction

  // Drive one cycle of inputs and enqueue what the outputs must be after the edge.
  task automatic step(input logic r, input logic c, input logic l, input logic a,
                      input logic [2:0] sel, input logic [3:0] dat,
                      input logic [2:0] eptr, input logic [7:0] eoh, input logic efd);
    exp_t e;
    @(negedge clk);
    rst = r; clear = c; load = l; auto_m = a; s = sel; d = dat;
    e.z = exp_z; e.ptr = eptr; e.oh = eoh; e.fd = efd; e.cnt = exp_cnt;
    q.push_back(e);
  endtask

  // Monitor: after every active edge, pop the pending expectation and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        for (int i = 0; i < 8; i++) check($sformatf("z%0d", i), 32'(z[i]), 32'(e.z[i]));
        check("ptr", 32'(ptr), 32'(e.ptr));
        check("wr_onehot", 32'(wr_onehot), 32'(e.oh));
        check("frame_done", 32'(frame_done), 32'(e.fd));
`ifdef DEMUX_FRAME_CNT_EN
        check("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
`endif
      end
    end
  end

  initial begin
    // 1: reset
    step(1, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    step(1, 0, 0, 0, 0, 0, 0, 8'h00, 0);
    step(0, 0, 0, 0, 0, 0, 0, 8'h00, 0);

    // 2: manual write lane 5
    exp_z[5] = 4'hA;
    step(0, 0, 1, 0, 3'd5, 4'hA, 0, 8'h20, 0);
    step(0, 0, 0, 0, 3'd5, 4'h3, 0, 8'h00, 0);

    // 3: full auto frame, d=1..8
    for (int i = 0; i < 8; i++) begin
      exp_z[i] = 4'(i + 1);
      step(0, 0, 1, 1, 3'd0, 4'(i + 1), 3'(i + 1), 8'(1 << i), (i == 7));
    end
    step(0, 0, 0, 1, 3'd0, 4'h0, 0, 8'h00, 0);

    // 4: mode switch mid-frame keeps ptr
    exp_z[0] = 4'hC; step(0, 0, 1, 1, 3'd6, 4'hC, 3'd1, 8'h01, 0);
    exp_z[1] = 4'hD; step(0, 0, 1, 1, 3'd6, 4'hD, 3'd2, 8'h02, 0);
    exp_z[2] = 4'hE; step(0, 0, 1, 1, 3'd6, 4'hE, 3'd3, 8'h04, 0);
    exp_z[7] = 4'h9; step(0, 0, 1, 0, 3'd7, 4'h9, 3'd3, 8'h80, 0);
    exp_z[3] = 4'hF; step(0, 0, 1, 1, 3'd0, 4'hF, 3'd4, 8'h08, 0);
    // load=0 in auto mode: nothing moves
    step(0, 0, 0, 1, 3'd2, 4'h1, 3'd4, 8'h00, 0);

    // 5: clear concurrent with load
    exp_z = '0;
    step(0, 1, 1, 1, 3'd0, 4'h5, 3'd0, 8'h00, 0);
    exp_z[2] = 4'h6;
    step(0, 0, 1, 0, 3'd2, 4'h6, 3'd0, 8'h04, 0);

`ifdef DEMUX_FRAME_CNT_EN
    // 6: 257 frames wrap the counter to 1, then reset mid-frame
    exp_z = '0;
    step(0, 1, 0, 0, 3'd0, 4'h0, 3'd0, 8'h00, 0);
    for (int f = 0; f < 257; f++) begin
      for (int i = 0; i < 8; i++) begin
        exp_z[i] = 4'(f + i);
        if (i == 7) exp_cnt = exp_cnt + 8'd1;
        step(0, 0, 1, 1, 3'd0, 4'(f + i), 3'(i + 1), 8'(1 << i), (i == 7));
      end
    end
    for (int i = 0; i < 4; i++) begin
      exp_z[i] = 4'hB;
      step(0, 0, 1, 1, 3'd0, 4'hB, 3'(i + 1), 8'(1 << i), 0);
    end
    exp_z = '0; exp_cnt = '0;
    step(1, 0, 1, 1, 3'd0, 4'h7, 3'd0, 8'h00, 0);
`endif

    step(0, 0, 0, 0, 3'd0, 4'h0, 3'd0, 8'h00, 0);

    // Drain with a bounded wait.
    for (int t = 0; t < 10 && q.size() > 0; t++) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
